// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Purpose  : 16x-oversampling UART receiver, 8N1, LSB first. Runs on the
//            system clock only. It samples each bit at mid-bit, checks the
//            start and stop bits, and holds each received byte in a one-entry
//            valid/ready register.
// Ports    : clk       - system clock, all logic on posedge
//            rst       - synchronous reset, active-high
//            rx        - asynchronous serial input, idle high
//            rx_data   - received byte, valid while rx_valid=1
//            rx_valid  - byte available in holding register
//            rx_ready  - consumer accepts byte when rx_valid & rx_ready
//            frame_err - one-cycle pulse, stop bit sampled low
//            overrun   - one-cycle pulse, byte dropped because register full
//            busy      - high whenever the receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Clocks per oversample tick; must be at least 2.
    localparam int c_DIV = clk_freq / (baud_rate * 16);
    localparam int c_PW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_DATA  = 3'd2;
    localparam logic [2:0] c_S_STOP  = 3'd3;
    localparam logic [2:0] c_S_BREAK = 3'd4;

    logic            r_rx_meta;
    logic            r_rx_s;
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_PW-1:0] r_presc;
    logic [3:0]      r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_frame_err;
    logic            r_overrun;

    logic w_tick;
    logic w_tick_mid;
    logic w_tick_last;
    logic w_start_det;
    logic w_start_ok;
    logic w_sample_bit;
    logic w_deliver;
    logic w_ferr;

    // Two-flop synchronizer; both flops reset to the idle line level so a
    // reset can never look like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick      = (r_presc == c_PW'(c_DIV - 1));
    // The 8th tick lands at mid start bit; every 16th tick thereafter is
    // mid-bit of the following bit.
    assign w_tick_mid  = w_tick && (r_tick_cnt == 4'd7);
    assign w_tick_last = w_tick && (r_tick_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_det  = 1'b0;
        w_start_ok   = 1'b0;
        w_sample_bit = 1'b0;
        w_deliver    = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = c_S_START;
                    w_start_det = 1'b1;
                end
            end
            c_S_START: begin
                if (w_tick_mid) begin
                    if (!r_rx_s) begin
                        w_state_nxt = c_S_DATA;
                        w_start_ok  = 1'b1;
                    end else begin
                        // Low pulse shorter than half a bit: treat as noise.
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end
            c_S_DATA: begin
                if (w_tick_last) begin
                    w_sample_bit = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = c_S_STOP;
                    end
                end
            end
            c_S_STOP: begin
                if (w_tick_last) begin
                    if (r_rx_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = c_S_BREAK;
                    end
                end
            end
            c_S_BREAK: begin
                // Hold here until the line returns high so a stuck-low line
                // cannot start a new frame.
                if (r_rx_s) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Oversampling counters and the data shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            if (w_start_det || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_start_det || w_start_ok) begin
                r_tick_cnt <= 4'd0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end

            if (w_start_ok) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sample_bit) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_sample_bit) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
        end
    end

    // One-entry holding register plus the single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != c_S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os
// Purpose  : Self-checking bench for uart_rx_os. A line driver serialises
//            bytes. A reference model of the holding register predicts the
//            observable events: byte accepted, frame error, or overrun. A
//            monitor compares what the DUT presents against that queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int c_CLK_FREQ = 1600000;
    localparam int c_BAUD     = 10000;
    localparam int c_BIT      = c_CLK_FREQ / c_BAUD;   // 160 clocks per bit
    localparam int c_LAT      = 1523;                  // start edge to rx_valid

    localparam int K_BYTE = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last_byte_cyc = 0;
    ev_t  exp_q[$];

    // Reference model of the one-entry holding register.
    logic       m_full = 1'b0;
    logic [7:0] m_byte = 8'h00;

    uart_rx_os #(
        .clk_freq (c_CLK_FREQ),
        .baud_rate(c_BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            K_BYTE:  return "byte";
            K_FERR:  return "frame_err";
            default: return "overrun";
        endcase
    endfunction

    task automatic push(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s %02h expected nothing (cycle %0d)",
                     kname(kind), data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == K_BYTE && e.data !== data)) begin
                errors++;
                $display("FAIL event: got %s %02h expected %s %02h (cycle %0d)",
                         kname(kind), data, kname(e.kind), e.data, cyc);
            end
        end
    endtask

    // Inputs change 2 ns after posedge; the monitor samples on negedge, so a
    // valid&ready seen here is exactly the handshake taken at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err || overrun) begin
                checks++;
                if (frame_err && overrun) begin
                    errors++;
                    $display("FAIL pulse_exclusive: got frame_err=1 overrun=1 expected at most one (cycle %0d)", cyc);
                end
            end
            if (rx_valid && rx_ready) begin
                last_byte_cyc = cyc;
                observe(K_BYTE, rx_data);
            end
            if (frame_err) observe(K_FERR, 8'h00);
            if (overrun)   observe(K_OVR, 8'h00);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drive one 8N1 frame; the line is left at the stop-bit level.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        step(c_BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(c_BIT);
        end
        rx = stop_bit;
        step(c_BIT);
    endtask

    // Predict the outcome of a frame from the receiver's rules, then send it.
    task automatic send(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit) begin
            push(K_FERR, 8'h00);
        end else if (m_full) begin
            push(K_OVR, 8'h00);
        end else if (rx_ready) begin
            push(K_BYTE, b);
        end else begin
            m_full = 1'b1;
            m_byte = b;
        end
        drive_frame(b, stop_bit);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: got no end of test expected completion before 2 ms");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int t0;
        logic [7:0] b;
        int gap;

        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        step(5);
        @(negedge clk);
        chk("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("reset_rx_data", {24'b0, rx_data}, 32'h00);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_pulses", {30'b0, frame_err, overrun}, 32'd0);
        step(1);
        rst = 1'b0;
        step(20);

        // 1: single byte, latency and busy across the frame
        t0 = cyc;
        fork
            send(8'hA5, 1'b1);
            begin
                repeat (10) @(negedge clk);
                chk("busy_early", {31'b0, busy}, 32'd1);
                repeat (790) @(negedge clk);
                chk("busy_mid", {31'b0, busy}, 32'd1);
                repeat (700) @(negedge clk);
                chk("busy_late", {31'b0, busy}, 32'd1);
            end
        join
        checks++;
        if (last_byte_cyc - t0 < c_LAT - 10 || last_byte_cyc - t0 > c_LAT + 10) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d +/- 10", last_byte_cyc - t0, c_LAT);
        end
        @(negedge clk);
        chk("valid_one_cycle", {31'b0, rx_valid}, 32'd0);
        chk("busy_after_frame", {31'b0, busy}, 32'd0);
        step(50);

        // 2: short glitch is rejected at mid start bit
        rx = 1'b0;
        step(40);
        @(negedge clk);
        chk("glitch_busy", {31'b0, busy}, 32'd1);
        rx = 1'b1;
        step(60);
        @(negedge clk);
        chk("glitch_idle", {31'b0, busy}, 32'd0);
        step(20);

        // 3: framing error, held-low line, then recovery
        send(8'h3C, 1'b0);
        step(400);
        @(negedge clk);
        chk("break_busy", {31'b0, busy}, 32'd1);
        chk("break_no_valid", {31'b0, rx_valid}, 32'd0);
        rx = 1'b1;
        step(10);
        @(negedge clk);
        chk("break_exit", {31'b0, busy}, 32'd0);
        send(8'h55, 1'b1);
        step(50);

        // 4: holding register full, overrun, then late accept
        rx_ready = 1'b0;
        send(8'h11, 1'b1);
        step(20);
        @(negedge clk);
        chk("hold_valid", {31'b0, rx_valid}, 32'd1);
        chk("hold_data", {24'b0, rx_data}, 32'h11);
        send(8'h22, 1'b1);
        step(20);
        @(negedge clk);
        chk("ovr_keep_data", {24'b0, rx_data}, 32'h11);
        push(K_BYTE, m_byte);
        m_full   = 1'b0;
        rx_ready = 1'b1;
        step(1);
        @(negedge clk);
        chk("accept_drop_valid", {31'b0, rx_valid}, 32'd0);
        chk("accept_keep_data", {24'b0, rx_data}, 32'h11);
        step(20);

        // 5: back-to-back frames, no idle gap
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h81, 1'b1);
        step(50);

        // 6: reset during data bit 4 of 0x99; the transmitter abandons the
        // frame, so the line goes idle after the reset
        rx = 1'b0;
        step(c_BIT);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h99 >> i) & 8'h01;
            step(c_BIT);
        end
        rx = 1'b1;
        step(c_BIT / 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        step(5 * c_BIT);
        @(negedge clk);
        chk("rst_mid_no_valid", {31'b0, rx_valid}, 32'd0);
        send(8'h42, 1'b1);
        step(50);

        // Randomized frames with occasional framing errors and random gaps
        for (int n = 0; n < 20; n++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 200);
            if ($urandom_range(0, 9) == 0) begin
                send(b, 1'b0);
                step($urandom_range(1, 300));
                rx = 1'b1;
                step(20 + gap);
            end else begin
                send(b, 1'b1);
                step(gap);
            end
        end

        step(300);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
16x-oversampling UART receiver (8N1, LSB first) running entirely on the system clock, with no derived clock. Decodes the serial stream produced by the team's UART transmitter into bytes. Samples at mid-bit and validates start and stop bits. Holds each byte in a one-entry valid/ready output register for the downstream consumer. Sits beside the transmitter in the UART top level as the robust receive path.

Parameters:
clk_freq, 1000000, system clock frequency in Hz
baud_rate, 9600, serial bit rate in bits/s
(derived, local) DIV = clk_freq/(baud_rate*16), integer truncation; DIV >= 2 required

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
rx  input  1  asynchronous serial input, idle high
rx_data  output  8  received byte, valid while rx_valid=1
rx_valid  output  1  byte available in holding register
rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready
frame_err  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: byte completed while holding register still full
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clock and reset only, synchronous active-high. State=IDLE; prescaler=0, tick counter=0, bit counter=0; rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0; both synchronizer flops=1.
- Synchronizer: rx passes through 2 flops (rx_s). Only rx_s is used by the FSM.
- Prescaler: counts 0..DIV-1 and emits a tick when it reaches DIV-1, then wraps to 0. Forced to 0 on start detection.
- Tick counter: 0..15, advances on tick.
- IDLE: when rx_s==0, go to START and clear prescaler and tick counter.
- START: on the 8th tick (mid start bit), sample rx_s.
  - rx_s==0: go to DATA, tick counter=0, bit counter=0.
  - rx_s==1: glitch; return to IDLE with no output.
- DATA: every 16th tick, shift rx_s in at MSB (shift right, LSB arrives first). After 8 samples go to STOP.
- STOP: on the 16th tick, sample rx_s.
  - rx_s==1: deliver byte (see holding rules), go to IDLE.
  - rx_s==0: pulse frame_err for 1 cycle, discard byte, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. Prevents a held-low line from re-triggering.
- Holding register:
  - Delivery with rx_valid=0, or with rx_valid=1 & rx_ready=1 in the same cycle: rx_data<=byte, rx_valid<=1 on the next clock.
  - Delivery with rx_valid=1 & rx_ready=0: keep the old byte, drop the new one, pulse overrun for 1 cycle.
  - rx_valid & rx_ready with no delivery: rx_valid<=0 next clock. rx_data holds its last value.
- Latency: rx_valid rises 1 clk after the stop sample, i.e. 2 sync + 8*DIV + 8*16*DIV + 16*DIV + 1 clocks after the rx falling edge (±1 DIV for edge phase).
- Reset mid-frame: abort immediately; the partial byte is lost and no pulses are issued. After rst deasserts, wait for the next falling edge.
- frame_err and overrun never assert together. rx_data is never updated on a framing error.

Test Plan:
Use clk_freq=1600000, baud_rate=10000 (DIV=10, 160 clk/bit) for all cases.
1. Send 0xA5 (8N1) with rx_ready=1 -> rx_valid 1-cycle high with rx_data=8'hA5, 1523±10 clk after start edge; busy high throughout frame.
2. Drive a 40-clk low glitch on idle rx -> START aborts at mid-bit; no rx_valid, no frame_err; busy returns low ~82 clk after glitch.
3. Send 0x3C with the stop bit forced 0, then hold rx low for 400 clk -> frame_err pulses once; rx_valid stays 0; FSM stays in BREAK until rx=1; next frame 0x55 received correctly.
4. rx_ready=0; send 0x11 then 0x22 -> rx_data=8'h11 held with rx_valid=1; overrun pulses at the end of the second frame. Raise rx_ready -> rx_valid drops next clk; rx_data remains 8'h11.
5. Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap and rx_ready=1 -> three rx_valid pulses with the correct data; no errors.
6. Assert rst for 1 clk during data bit 4 of 0x99 -> no rx_valid or pulses for that frame; the next frame 0x42 is received as 8'h42.
